// File: rtl/md_pkg.sv
// Shared definitions for the mult/div request arbiter: op encodings,
// the "no command" op value and the FSM state enum.
package md_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MFHI  = 3'b110;
    localparam logic [2:0] OP_MFLO  = 3'b111;

    // Idle value of md_op; the unit never treats it as a write.
    localparam logic [2:0] MD_OP_NOP = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BSY,
        RUN,
        DONE
    } state_e;

    // mult/multu/div/divu need a start pulse and a busy phase
    function automatic logic is_unit_op(input logic [2:0] op);
        return !op[2];
    endfunction

    // mthi/mtlo write hi/lo with a single non-start command cycle
    function automatic logic is_move_to(input logic [2:0] op);
        return op[2] && !op[1];
    endfunction

endpackage

// File: rtl/md_arbiter_rr_arb2.sv
// Two-way round-robin grant. ptr names the requester with priority; it
// moves to the other requester only when a grant is actually accepted.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    logic ptr;

    // grant the priority requester if it asks, otherwise the other one
    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (req[ptr])
                grant[ptr] = 1'b1;
            else if (req[~ptr])
                grant[~ptr] = 1'b1;
        end
    end

    // priority passes to whoever was not just served
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            ptr <= 1'b0;
        else if (accept)
            ptr <= grant[0];
    end

endmodule

// File: rtl/md_arbiter.sv
// Arbitrates two requesters onto a single shared mult/div unit and
// returns the hi/lo result to the owner of each transaction.
// Optional: define MD_ARB_TIMEOUT_EN to build a busy watchdog that
// raises a sticky err after TIMEOUT_CYC cycles waiting on the unit.
module md_arbiter
    import md_pkg::*;
#(
    parameter int TIMEOUT_CYC = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    input  logic [1:0][2:0]  req_op,
    input  logic [1:0][31:0] req_a,
    input  logic [1:0][31:0] req_b,
    output logic [1:0]       req_ready,
    output logic [1:0]       rsp_valid,
    output logic [31:0]      rsp_hi,
    output logic [31:0]      rsp_lo,
    output logic             md_start,
    output logic [2:0]       md_op,
    output logic [31:0]      md_rs,
    output logic [31:0]      md_rt,
    input  logic             md_busy,
    input  logic [31:0]      md_hi,
    input  logic [31:0]      md_lo,
    output logic             err
);

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("md_arbiter: TIMEOUT_CYC must be at least 1");
    end

    state_e     state, state_nxt;
    logic       owner;
    logic [2:0] op;
    logic [1:0] grant;
    logic       arb_en;
    logic       accept;
    logic       timeout;
    logic       sel;

    // ready is held low during reset even though state is already IDLE
    assign arb_en    = (state == IDLE) && reset;
    assign req_ready = grant;
    assign accept    = |(req_valid & req_ready);
    assign sel       = grant[1];

    rr_arb2 u_rr (
        .clk    (clk),
        .reset  (reset),
        .en     (arb_en),
        .req    (req_valid),
        .accept (accept),
        .grant  (grant)
    );

`ifdef MD_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] wait_cnt;
    logic          waiting;
    logic          err_q;

    assign waiting = (state == WAIT_BSY) || (state == RUN);
    assign timeout = waiting && (wait_cnt == CW'(TIMEOUT_CYC - 1));
    assign err     = err_q;

    // count cycles spent waiting on the unit; latch err on expiry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            wait_cnt <= waiting ? wait_cnt + 1'b1 : '0;
            if (timeout)
                err_q <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    // capture owner, op and operands of the accepted request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner <= 1'b0;
            op    <= MD_OP_NOP;
            md_rs <= '0;
            md_rt <= '0;
        end else if (accept) begin
            owner <= sel;
            op    <= req_op[sel];
            md_rs <= req_a[sel];
            md_rt <= req_b[sel];
        end
    end

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // next state plus unit command and response outputs
    always_comb begin
        state_nxt = state;
        md_start  = 1'b0;
        md_op     = MD_OP_NOP;
        rsp_valid = 2'b00;
        rsp_hi    = '0;
        rsp_lo    = '0;
        case (state)
            IDLE: begin
                if (accept)
                    state_nxt = ISSUE;
            end
            ISSUE: begin
                if (is_unit_op(op)) begin
                    md_start  = 1'b1;
                    md_op     = op;
                    state_nxt = WAIT_BSY;
                end else begin
                    // mfhi/mflo issue nothing; md_op stays NOP
                    if (is_move_to(op))
                        md_op = op;
                    state_nxt = DONE;
                end
            end
            WAIT_BSY: begin
                if (timeout)
                    state_nxt = IDLE;
                else if (md_busy)
                    state_nxt = RUN;
            end
            RUN: begin
                // a real completion wins over a same-cycle expiry
                if (!md_busy)
                    state_nxt = DONE;
                else if (timeout)
                    state_nxt = IDLE;
            end
            DONE: begin
                rsp_valid[owner] = 1'b1;
                rsp_hi           = md_hi;
                rsp_lo           = md_lo;
                state_nxt        = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_md_arbiter.sv
// Scoreboard bench for md_arbiter. A behavioural mult/div unit drives the
// unit side; accepted requests push expected responses computed from an
// architectural hi/lo model, and a monitor pops them on rsp_valid.
module tb_md_arbiter;
    import md_pkg::*;

    localparam int TO = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [1:0]       req_valid = '0;
    logic [1:0][2:0]  req_op = '0;
    logic [1:0][31:0] req_a = '0;
    logic [1:0][31:0] req_b = '0;
    logic [1:0]       req_ready, rsp_valid;
    logic [31:0]      rsp_hi, rsp_lo;
    logic             md_start;
    logic [2:0]       md_op;
    logic [31:0]      md_rs, md_rt;
    logic             md_busy;
    logic [31:0]      md_hi, md_lo;
    logic             err;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    md_arbiter #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_hi(rsp_hi), .rsp_lo(rsp_lo),
        .md_start(md_start), .md_op(md_op), .md_rs(md_rs), .md_rt(md_rt),
        .md_busy(md_busy), .md_hi(md_hi), .md_lo(md_lo), .err(err)
    );

    // mult/div arithmetic as the unit defines it: {hi, lo}
    function automatic logic [63:0] unit_calc(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            OP_MULT:  return 64'(sa * sb);
            OP_MULTU: return {32'b0, a} * {32'b0, b};
            OP_DIV:   return (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
            OP_DIVU:  return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default:  return 64'b0;
        endcase
    endfunction

    // ---------------- behavioural mult/div unit ----------------
    logic        u_busy;
    logic        force_busy = 1'b0;
    int          unit_lat = 2;
    int          u_cnt;
    int          last_n;
    logic [63:0] u_res;
    logic [31:0] u_hi, u_lo;

    assign md_busy = u_busy | force_busy;
    assign md_hi   = u_hi;
    assign md_lo   = u_lo;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            u_busy <= 1'b0; u_cnt <= 0; u_hi <= '0; u_lo <= '0; u_res <= '0; last_n <= 0;
        end else if (md_start) begin
            u_busy <= 1'b1; u_cnt <= unit_lat; last_n <= unit_lat;
            u_res  <= unit_calc(md_op, md_rs, md_rt);
        end else if (u_busy) begin
            if (u_cnt == 1) begin
                u_busy <= 1'b0; u_hi <= u_res[63:32]; u_lo <= u_res[31:0];
            end else begin
                u_cnt <= u_cnt - 1;
            end
        end else if (md_op == OP_MTHI) begin
            u_hi <= md_rs;
        end else if (md_op == OP_MTLO) begin
            u_lo <= md_rt;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        owner;
        logic [2:0]  op;
        logic [31:0] hi;
        logic [31:0] lo;
        int          acc;
    } exp_t;

    exp_t        q[$];
    logic [31:0] ref_hi = '0, ref_lo = '0;
    int          last_grant = 1;
    int          n_start = 0, n_cmd = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!reset) begin
                // the unit's own reset clears hi/lo; in-flight work is abandoned
                q.delete(); ref_hi = '0; ref_lo = '0; last_grant = 1;
                check("rsp_valid_in_reset", {62'b0, rsp_valid}, 64'b0);
            end else begin
                if (md_start) n_start++;
                if (md_op != MD_OP_NOP) n_cmd++;
                if (q.size() != 0)
                    check("ready_while_busy", {62'b0, req_ready}, 64'b0);
                if (|(req_valid & req_ready)) begin
                    int          idx, want;
                    logic [63:0] r;
                    exp_t        e;
                    idx  = req_ready[1] ? 1 : 0;
                    want = (&req_valid) ? 1 - last_grant : (req_valid[1] ? 1 : 0);
                    check("grant_onehot", {62'b0, req_ready}, (idx == 1) ? 64'd2 : 64'd1);
                    check("rr_winner", 64'(idx), 64'(want));
                    last_grant = idx;
                    case (req_op[idx])
                        OP_MTHI: ref_hi = req_a[idx];
                        OP_MTLO: ref_lo = req_b[idx];
                        OP_MFHI, OP_MFLO: ;
                        default: begin
                            r = unit_calc(req_op[idx], req_a[idx], req_b[idx]);
                            ref_hi = r[63:32]; ref_lo = r[31:0];
                        end
                    endcase
                    e.owner = idx[0]; e.op = req_op[idx]; e.hi = ref_hi; e.lo = ref_lo; e.acc = cyc + 1;
                    q.push_back(e);
                    n_start = 0; n_cmd = 0;
                end
                if (|rsp_valid) begin
                    if (q.size() == 0) begin
                        check("unexpected_rsp", {62'b0, rsp_valid}, 64'b0);
                    end else begin
                        exp_t e;
                        int   lat;
                        e   = q.pop_front();
                        lat = is_unit_op(e.op) ? 3 + last_n : 2;
                        check("rsp_owner", {62'b0, rsp_valid}, e.owner ? 64'd2 : 64'd1);
                        check("rsp_hi", 64'(rsp_hi), 64'(e.hi));
                        check("rsp_lo", 64'(rsp_lo), 64'(e.lo));
                        check("latency", 64'(cyc + 1 - e.acc), 64'(lat));
                        check("start_pulses", 64'(n_start), is_unit_op(e.op) ? 64'd1 : 64'd0);
                        check("cmd_cycles", 64'(n_cmd), (e.op <= OP_MTLO) ? 64'd1 : 64'd0);
                    end
                end
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int i, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        req_op[i] = o; req_a[i] = a; req_b[i] = b; req_valid[i] = 1'b1;
    endtask

    task automatic wait_accept(input int i);
        int k;
        for (k = 0; k < 500; k++) begin
            @(negedge clk);
            if (req_ready[i]) break;
        end
        if (k == 500) check("accept_timeout", 64'(i), 64'hFF);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic send(input int i, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        drive(i, o, a, b);
        wait_accept(i);
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (q.size() == 0) break;
        end
        if (k == 300) check("drain_timeout", 64'(q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_req_ready", {62'b0, req_ready}, 64'b0);
        check("rst_rsp_valid", {62'b0, rsp_valid}, 64'b0);
        check("rst_rsp_hi", 64'(rsp_hi), 64'b0);
        check("rst_rsp_lo", 64'(rsp_lo), 64'b0);
        check("rst_md_start", 64'(md_start), 64'b0);
        check("rst_md_op", 64'(md_op), 64'h7);
        check("rst_md_rs", 64'(md_rs), 64'b0);
        check("rst_md_rt", 64'(md_rt), 64'b0);
        check("rst_err", 64'(err), 64'b0);
    endtask

    task automatic rand_drv(input int i, input int n);
        for (int k = 0; k < n; k++) begin
            logic [2:0]  o;
            logic [31:0] b;
            o = 3'($urandom_range(0, 7));
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            unit_lat = $urandom_range(1, 5);
            send(i, o, $urandom, b);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
    endtask

    // ---------------- main ----------------
    initial begin
        fork
            forever begin @(posedge clk); cyc++; end
            monitor();
            begin
                #12;
                check_reset_outputs();
                @(posedge clk); #1 reset = 1'b1;
                @(posedge clk); #1;

                // simultaneous requests with the pointer at requester 0
                drive(0, OP_DIVU, 32'd100, 32'd7);
                drive(1, OP_MTHI, 32'd5, 32'd0);
                fork
                    wait_accept(0);
                    wait_accept(1);
                join
                wait_idle();

                // signed multiply
                unit_lat = 3;
                send(0, OP_MULT, 32'hFFFF_FFFD, 32'd7);
                wait_idle();
                check("mult_hi_const", 64'(ref_hi), 64'hFFFF_FFFF);
                check("mult_lo_const", 64'(ref_lo), 64'hFFFF_FFEB);

                // move-to then move-from lo
                send(1, OP_MTLO, 32'hDEAD, 32'h1234);
                wait_idle();
                send(0, OP_MFLO, 32'd0, 32'd0);
                wait_idle();

                // reset in the middle of a divide
                unit_lat = 10;
                send(0, OP_DIV, 32'd1000, 32'd3);
                for (int k = 0; k < 50 && !md_busy; k++) @(negedge clk);
                @(posedge clk); #2 reset = 1'b0;
                #1 check_reset_outputs();
                repeat (2) @(posedge clk);
                #1 reset = 1'b1;
                @(posedge clk); #1;
                send(1, OP_MFHI, 32'd0, 32'd0);
                wait_idle();
                unit_lat = 2;
                send(0, OP_DIVU, 32'd50, 32'd8);
                wait_idle();

                // random traffic from both requesters at once
                fork
                    rand_drv(0, 40);
                    rand_drv(1, 40);
                join
                wait_idle();

`ifdef MD_ARB_TIMEOUT_EN
                force_busy = 1'b1;
                unit_lat = 3;
                send(0, OP_MULTU, 32'd9, 32'd9);
                repeat (TO) @(posedge clk);
                #1 check("err_before_limit", 64'(err), 64'd0);
                @(posedge clk);
                #1 check("err_at_limit", 64'(err), 64'd1);
                q.delete();
                force_busy = 1'b0;
                send(1, OP_MFHI, 32'd0, 32'd0);
                wait_idle();
                check("err_sticky", 64'(err), 64'd1);
`else
                check("err_tied_low", 64'(err), 64'd0);
`endif
                $display("[TB] %0d tests run, %0d failed", tests, fails);
                $finish;
            end
        join
    end

    // hard stop in case something wedges outside the bounded waits
    initial begin
        #2000000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/md_arbiter.md
MD_ARBITER -- requirements
Module: md_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 32, meaning the busy-watchdog limit (used only with MD_ARB_TIMEOUT_EN).
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have ports req_valid[i], input, 1, per requester i in {0,1}, meaning a request is offered.
REQ-005 The block SHALL have ports req_op[i], input, 3, meaning 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110 mfhi, 111 mflo.
REQ-006 The block SHALL have ports req_a[i] and req_b[i], input, 32 each, meaning operands (mthi uses a; mtlo uses b).
REQ-007 The block SHALL have ports req_ready[i], output, 1, meaning the request is accepted this cycle.
REQ-008 The block SHALL have ports rsp_valid[i], output, 1, meaning a one-cycle completion pulse to requester i.
REQ-009 The block SHALL have ports rsp_hi and rsp_lo, output, 32 each, meaning the result, shared by both requesters and qualified by rsp_valid.
REQ-010 The block SHALL have ports md_start (1), md_op (3), md_rs (32) and md_rt (32), outputs, driving the mult/div unit.
REQ-011 The block SHALL have ports md_busy (1), md_hi (32) and md_lo (32), inputs, from the mult/div unit.
REQ-012 The block SHALL have port err, output, 1, meaning a sticky watchdog error.

Function
REQ-013 The block SHALL use FSM states IDLE, ISSUE, WAIT_BSY, RUN and DONE.
REQ-014 In IDLE, the block SHALL grant at most one requester; on valid&&ready it SHALL latch owner, op and operands, then go to ISSUE.
REQ-015 Grant SHALL be round-robin: if both requesters are valid, the requester not granted last wins; the pointer SHALL update only on acceptance.
REQ-016 req_ready SHALL be asserted only in IDLE, only to the granted requester.
REQ-017 In ISSUE, for ops 000-011, the block SHALL drive md_start=1 and md_op=op for exactly one cycle, then go to WAIT_BSY.
REQ-018 In ISSUE, for ops 100/101, the block SHALL drive md_op=op with md_start=0 for exactly one cycle, then go to DONE.
REQ-019 In ISSUE, for ops 110/111, the block SHALL drive no unit command and go to DONE.
REQ-020 Outside ISSUE, md_op SHALL be 3'b111 and md_start SHALL be 0, so no spurious mthi/mtlo write occurs.
REQ-021 WAIT_BSY SHALL go to RUN when md_busy=1.
REQ-022 RUN SHALL go to DONE on the cycle md_busy is sampled 0.
REQ-023 In DONE, rsp_valid[owner] SHALL pulse for one cycle with rsp_hi=md_hi and rsp_lo=md_lo, then the FSM SHALL return to IDLE.
REQ-024 Latency SHALL be: mthi/mtlo/mfhi/mflo, rsp_valid 2 cycles after acceptance; mult/div, 3 + unit busy cycles.
REQ-025 Requests arriving while not in IDLE SHALL be held (req_ready=0) and SHALL NOT be dropped.
REQ-026 Divide by zero SHALL be passed through unchecked; the result is whatever the unit returns.

Reset
REQ-027 While reset=0, asynchronously: state=IDLE, RR pointer=requester 0, md_start=0, md_op=3'b111, md_rs=md_rt=0, rsp_valid=0, rsp_hi=rsp_lo=0, req_ready=0, err=0.
REQ-028 Reset mid-operation SHALL abandon the transaction with no rsp_valid; the unit's own reset clears it.

Configuration
REQ-029 With MD_ARB_TIMEOUT_EN defined, a counter SHALL run in WAIT_BSY/RUN; at TIMEOUT_CYC cycles the block SHALL set err, issue no rsp_valid, and return to IDLE.
REQ-030 Without MD_ARB_TIMEOUT_EN, no counter SHALL be built, err SHALL be constant 0, and WAIT_BSY/RUN SHALL wait indefinitely.

Structure
REQ-031 Shared package md_pkg SHALL hold the op encodings, the MD_OP_NOP=3'b111 constant and the FSM state enum.
REQ-032 Sub-module rr_arb2 SHALL implement the 2-way round-robin grant and pointer.

Verification
REQ-033 Requester 0 sends mult, a=-3, b=7 -> one md_start pulse; rsp_valid[0] with hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
REQ-034 Both valid in the same cycle with divu 100/7 and mthi 5, pointer=0 -> requester 0 served first (hi=2, lo=14), then requester 1 (rsp_hi=5).
REQ-035 mtlo b=0x1234 then mflo -> each rsp_valid 2 cycles after acceptance; mflo returns lo=0x1234; md_start stays 0.
REQ-036 reset driven low during RUN of div -> all outputs reach reset values immediately; no rsp_valid; next request completes correctly.
REQ-037 With MD_ARB_TIMEOUT_EN and md_busy tied high -> err=1 at cycle 32; FSM in IDLE; no rsp_valid.
